// File: rtl/rc5_core_param.sv
// Iterative RC5-w/r/b encrypt/decrypt core, one round per clock, valid/ready on both sides.
// Optional RC5_KEY_LATCH_EN: capture the subkey table at accept so the key may change mid-block.
module rc5_core_param #(
    parameter int W          = 16,
    parameter int MAX_ROUNDS = 16,
    parameter int RW         = $clog2(MAX_ROUNDS + 1)
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_in_valid,
    output logic                                o_in_ready,
    input  logic                                i_mode,
    input  logic [RW-1:0]                       i_num_rounds,
    input  logic [2*MAX_ROUNDS+1:0][W-1:0]      i_subkeys,
    input  logic [2*W-1:0]                      i_d_in,
    output logic                                o_out_valid,
    input  logic                                i_out_ready,
    output logic [2*W-1:0]                      o_d_out,
    output logic                                o_out_err,
    output logic                                o_busy
);
    localparam int NK = 2 * MAX_ROUNDS + 2;
    localparam int LW = $clog2(W);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t               r_state, w_state_nxt;
    logic [W-1:0]         r_a, r_b;
    logic [RW-1:0]        r_i, r_r;
    logic                 r_mode, r_err;
    logic [NK-1:0][W-1:0] w_sk;
    logic                 w_accept, w_bad, w_last;
    logic [RW:0]          w_k0, w_k1;
    logic [W-1:0]         w_ea, w_eb, w_da, w_db;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LW-1:0] n);
        logic [2*W-1:0] t;
        t = {x, x} << n;
        return t[2*W-1:W];
    endfunction

    function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [LW-1:0] n);
        logic [2*W-1:0] t;
        t = {x, x} >> n;
        return t[W-1:0];
    endfunction

    assign w_accept = (r_state == IDLE) && i_in_valid;
    assign w_bad    = i_num_rounds > RW'(MAX_ROUNDS);

`ifdef RC5_KEY_LATCH_EN
    logic [NK-1:0][W-1:0] r_sk;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)         r_sk <= '0;
        else if (w_accept) r_sk <= i_subkeys;
    end
    assign w_sk = r_sk;
`else
    assign w_sk = i_subkeys;
`endif

    // Decrypt walks the counter down from R to 1, encrypt walks it up from 1 to R.
    assign w_last = r_mode ? (r_i == RW'(1)) : (r_i == r_r);
    assign w_k0   = {r_i, 1'b0};
    assign w_k1   = {r_i, 1'b1};

    assign w_ea = rotl(r_a ^ r_b, r_b[LW-1:0]) + w_sk[w_k0];
    assign w_eb = rotl(r_b ^ w_ea, w_ea[LW-1:0]) + w_sk[w_k1];
    assign w_db = rotr(r_b - w_sk[w_k1], r_a[LW-1:0]) ^ r_a;
    assign w_da = rotr(r_a - w_sk[w_k0], w_db[LW-1:0]) ^ w_db;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        o_busy      = 1'b1;
        o_out_err   = 1'b0;
        o_d_out     = '0;
        case (r_state)
            IDLE: begin
                o_in_ready = 1'b1;
                o_busy     = 1'b0;
                if (i_in_valid)
                    w_state_nxt = (w_bad || i_num_rounds == '0) ? DONE : ROUND;
            end
            ROUND: begin
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                o_out_valid = 1'b1;
                o_out_err   = r_err;
                // Bad-round requests pass the block through untouched.
                o_d_out     = (r_err || !r_mode) ? {r_b, r_a}
                                                 : {r_b - w_sk[1], r_a - w_sk[0]};
                if (i_out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_i    <= '0;
            r_r    <= '0;
            r_mode <= 1'b0;
            r_err  <= 1'b0;
        end else if (w_accept) begin
            r_mode <= i_mode;
            r_r    <= i_num_rounds;
            r_err  <= w_bad;
            if (w_bad || i_mode) begin
                r_a <= i_d_in[W-1:0];
                r_b <= i_d_in[2*W-1:W];
                r_i <= w_bad ? '0 : i_num_rounds;
            end else begin
                r_a <= i_d_in[W-1:0] + i_subkeys[0];
                r_b <= i_d_in[2*W-1:W] + i_subkeys[1];
                r_i <= RW'(1);
            end
        end else if (r_state == ROUND) begin
            if (r_mode) begin
                r_a <= w_da;
                r_b <= w_db;
                r_i <= r_i - RW'(1);
            end else begin
                r_a <= w_ea;
                r_b <= w_eb;
                r_i <= r_i + RW'(1);
            end
        end
    end
endmodule

// File: tb/tb_rc5_core_param.sv
// Bench for rc5_core_param: W=16 and W=32 instances against a loop-level RC5 reference model.
module tb_rc5_core_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        iv   [2];
    logic        md   [2];
    logic [4:0]  nr   [2];
    logic [63:0] din  [2];
    logic        ordy [2];
    logic [31:0] S    [2][34];

    logic [33:0][15:0] k16;
    logic [33:0][31:0] k32;
    always_comb begin
        for (int k = 0; k < 34; k++) begin
            k16[k] = S[0][k][15:0];
            k32[k] = S[1][k];
        end
    end

    logic        ir16, ov16, er16, bz16, ir32, ov32, er32, bz32;
    logic [31:0] do16;
    logic [63:0] do32;
    logic        ir [2], ov [2], er [2], bz [2];
    logic [63:0] dout [2];
    always_comb begin
        ir[0] = ir16; ov[0] = ov16; er[0] = er16; bz[0] = bz16; dout[0] = {32'b0, do16};
        ir[1] = ir32; ov[1] = ov32; er[1] = er32; bz[1] = bz32; dout[1] = do32;
    end

    rc5_core_param #(.W(16), .MAX_ROUNDS(16)) u16 (
        .i_clk(clk), .i_rst(rst), .i_in_valid(iv[0]), .o_in_ready(ir16), .i_mode(md[0]),
        .i_num_rounds(nr[0]), .i_subkeys(k16), .i_d_in(din[0][31:0]), .o_out_valid(ov16),
        .i_out_ready(ordy[0]), .o_d_out(do16), .o_out_err(er16), .o_busy(bz16));

    rc5_core_param #(.W(32), .MAX_ROUNDS(16)) u32 (
        .i_clk(clk), .i_rst(rst), .i_in_valid(iv[1]), .o_in_ready(ir32), .i_mode(md[1]),
        .i_num_rounds(nr[1]), .i_subkeys(k32), .i_d_in(din[1]), .o_out_valid(ov32),
        .i_out_ready(ordy[1]), .o_d_out(do32), .o_out_err(er32), .o_busy(bz32));

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] msk(input int w);
        return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] rl(input logic [63:0] x, input logic [63:0] s, input int w);
        int sh;
        sh = int'(s % 64'(w));
        if (sh == 0) return x;
        return ((x << sh) | (x >> (w - sh))) & msk(w);
    endfunction

    function automatic logic [63:0] rr(input logic [63:0] x, input logic [63:0] s, input int w);
        int sh;
        sh = int'(s % 64'(w));
        if (sh == 0) return x;
        return ((x >> sh) | (x << (w - sh))) & msk(w);
    endfunction

    function automatic logic [63:0] key(input int n, input int k);
        return 64'(S[n][k]) & msk(n != 0 ? 32 : 16);
    endfunction

    function automatic logic [63:0] rc5_ref(input int n, input bit dec, input int r, input logic [63:0] blk);
        int w;
        logic [63:0] m, a, b;
        w = (n != 0) ? 32 : 16;
        m = msk(w);
        a = blk & m;
        b = (blk >> w) & m;
        if (!dec) begin
            a = (a + key(n, 0)) & m;
            b = (b + key(n, 1)) & m;
            for (int i = 1; i <= r; i++) begin
                a = (rl(a ^ b, b, w) + key(n, 2*i)) & m;
                b = (rl(b ^ a, a, w) + key(n, 2*i+1)) & m;
            end
        end else begin
            for (int i = r; i >= 1; i--) begin
                b = rr((b - key(n, 2*i+1)) & m, a, w) ^ a;
                a = rr((a - key(n, 2*i)) & m, b, w) ^ b;
            end
            b = (b - key(n, 1)) & m;
            a = (a - key(n, 0)) & m;
        end
        return (b << w) | a;
    endfunction

    // Transaction-level model: a block is accepted when idle, its result appears R cycles later
    // (immediately for R=0 or an illegal R) and leaves on the out handshake.
    bit          m_busy  [2] = '{0, 0};
    bit          m_valid [2] = '{0, 0};
    bit          m_err   [2] = '{0, 0};
    int          m_cnt   [2] = '{0, 0};
    logic [63:0] m_res   [2] = '{0, 0};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < 2; n++) begin
                m_busy[n] <= 0; m_valid[n] <= 0; m_err[n] <= 0; m_cnt[n] <= 0; m_res[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (m_valid[n]) begin
                    if (ordy[n]) begin m_valid[n] <= 0; m_busy[n] <= 0; end
                end else if (m_busy[n]) begin
                    if (m_cnt[n] == 1) m_valid[n] <= 1;
                    m_cnt[n] <= m_cnt[n] - 1;
                end else if (iv[n]) begin
                    m_busy[n] <= 1;
                    m_err[n]  <= (nr[n] > 16);
                    m_res[n]  <= (nr[n] > 16) ? (din[n] & msk(n != 0 ? 64 : 32))
                                              : rc5_ref(n, md[n], int'(nr[n]), din[n]);
                    m_cnt[n]  <= (nr[n] > 16) ? 0 : int'(nr[n]);
                    m_valid[n] <= (nr[n] > 16) || (nr[n] == 0);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int n = 0; n < 2; n++) begin
                chk("cmp_in_ready", 64'(ir[n]), 64'(!m_busy[n]));
                chk("cmp_busy", 64'(bz[n]), 64'(m_busy[n]));
                chk("cmp_out_valid", 64'(ov[n]), 64'(m_valid[n]));
                if (m_valid[n]) begin
                    chk("cmp_d_out", dout[n], m_res[n]);
                    chk("cmp_out_err", 64'(er[n]), 64'(m_err[n]));
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic run(input int n, input bit dec, input int r, input logic [63:0] blk,
                       output logic [63:0] res, output bit err);
        int lat;
        bit seen;
        iv[n] = 1'b1; md[n] = dec; nr[n] = 5'(r); din[n] = blk;
        @(posedge clk);
        #1 iv[n] = 1'b0;
        lat = 0; seen = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            lat++;
            if (ov[n]) begin seen = 1; break; end
        end
        if (!seen) chk("out_valid_timeout", 64'(ov[n]), 64'd1);
        chk("latency", 64'(lat), 64'((r > 16) ? 1 : r + 1));
        res = dout[n];
        err = er[n];
        if (ordy[n]) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    logic [63:0] res, pt, ct, held, expv;
    bit          e, spur;
    int          rlist [5] = '{12, 12, 16, 0, 5};

    initial begin
        for (int n = 0; n < 2; n++) begin
            iv[n] = 0; md[n] = 0; nr[n] = '0; din[n] = '0; ordy[n] = 1;
            for (int k = 0; k < 34; k++) S[n][k] = '0;
        end
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(ir16), 64'd1);
        chk("rst_out_valid", 64'(ov16), 64'd0);
        chk("rst_d_out", 64'(do16), 64'd0);
        chk("rst_out_err", 64'(er16), 64'd0);
        chk("rst_busy", 64'(bz16), 64'd0);
        rst = 0;
        @(negedge clk);

        // R=0 encrypt: whitening only
        S[0][0] = 32'h1; S[0][1] = 32'h2;
        chk("model_t1", rc5_ref(0, 0, 0, 64'h00050003), 64'h00070004);
        run(0, 0, 0, 64'h00050003, res, e);
        chk("t1_d_out", res, 64'h00070004);

        // R=1 with an all-zero table, both directions
        S[0][0] = '0; S[0][1] = '0;
        chk("model_t2_enc", rc5_ref(0, 0, 1, 64'h1), 64'h00020001);
        chk("model_t2_dec", rc5_ref(0, 1, 1, 64'h00020001), 64'h1);
        run(0, 0, 1, 64'h1, res, e);
        chk("t2_enc", res, 64'h00020001);
        run(0, 1, 1, 64'h00020001, res, e);
        chk("t2_dec", res, 64'h1);

        // random round trips on both widths
        for (int n = 0; n < 2; n++) begin
            for (int k = 0; k < 34; k++) S[n][k] = $urandom;
            foreach (rlist[t]) begin
                pt = (n != 0) ? {$urandom, $urandom} : {32'b0, $urandom};
                run(n, 0, rlist[t], pt, ct, e);
                run(n, 1, rlist[t], ct, res, e);
                chk("roundtrip", res, pt);
            end
        end

        // output backpressure: result held, input ignored
        ordy[0] = 0;
        run(0, 0, 3, 64'h12345678, held, e);
        for (int c = 0; c < 5; c++) begin
            iv[0] = 1; din[0] = {32'b0, $urandom}; md[0] = 1; nr[0] = 5'd2;
            @(negedge clk);
            chk("bp_d_out_stable", dout[0], held);
            chk("bp_in_ready", 64'(ir16), 64'd0);
            chk("bp_out_valid", 64'(ov16), 64'd1);
        end
        iv[0] = 0; ordy[0] = 1;
        @(negedge clk);
        chk("bp_release_idle", 64'(ir16), 64'd1);
        chk("bp_release_valid", 64'(ov16), 64'd0);

        // illegal round counts pass data through and raise out_err
        run(0, 0, 17, 64'hDEADBEEF, res, e);
        chk("bad_r_d_out", res, 64'hDEADBEEF);
        chk("bad_r_err", 64'(e), 64'd1);
        run(0, 1, 31, 64'h0BADF00D, res, e);
        chk("bad_r31_d_out", res, 64'h0BADF00D);
        chk("bad_r31_err", 64'(e), 64'd1);

        // asynchronous reset in the middle of round 3 of 8
        iv[0] = 1; md[0] = 0; nr[0] = 5'd8; din[0] = 64'hCAFEF00D;
        @(posedge clk);
        #1 iv[0] = 0;
        repeat (2) @(posedge clk);
        #2 rst = 1;
        #1;
        chk("arst_in_ready", 64'(ir16), 64'd1);
        chk("arst_out_valid", 64'(ov16), 64'd0);
        chk("arst_d_out", 64'(do16), 64'd0);
        chk("arst_busy", 64'(bz16), 64'd0);
        chk("arst_out_err", 64'(er16), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        spur = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ov16) spur = 1;
        end
        chk("arst_no_spurious", 64'(spur), 64'd0);
        pt = {32'b0, $urandom};
        run(0, 0, 8, pt, ct, e);
        chk("post_rst_enc", ct, rc5_ref(0, 0, 8, pt));

`ifdef RC5_KEY_LATCH_EN
        // key may change after accept
        pt = {32'b0, $urandom};
        expv = rc5_ref(0, 0, 8, pt);
        iv[0] = 1; md[0] = 0; nr[0] = 5'd8; din[0] = pt;
        @(posedge clk);
        #1 iv[0] = 0;
        for (int k = 0; k < 34; k++) S[0][k] = $urandom;
        spur = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (ov16) begin spur = 1; break; end
        end
        chk("latch_valid", 64'(spur), 64'd1);
        chk("latch_d_out", dout[0], expv);
        @(posedge clk);
        @(negedge clk);
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
